// File: rtl/eink_panel_decoder.sv
// Loopback decoder for the ED060SC7 drive strobes: rebuilds frame/row/column
// structure from registered pins and emits per-byte, per-line and per-frame records.
module eink_panel_decoder #(
    parameter int COLS  = 200,
    parameter int ROWS  = 600,
    parameter int COL_W = 8,
    parameter int ROW_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gmode,
    input  logic             i_spv,
    input  logic             i_ckv,
    input  logic             i_cl,
    input  logic             i_le,
    input  logic             i_oe,
    input  logic             i_sph,
    input  logic [7:0]       i_data,
    input  logic             i_err_clr,
    output logic             o_pix_valid,
    output logic [7:0]       o_pix_data,
    output logic [COL_W-1:0] o_pix_col,
    output logic [ROW_W-1:0] o_pix_row,
    output logic             o_line_done,
    output logic [COL_W:0]   o_line_bytes,
    output logic [ROW_W-1:0] o_line_row,
    output logic             o_line_oe,
    output logic             o_frame_start,
    output logic             o_frame_done,
    output logic             o_busy,
    output logic             o_err_overrun,
    output logic             o_err_short,
    output logic             o_err_order
);

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_ACTIVE = 1'b1;
    localparam logic [COL_W-1:0] COLS_C  = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROWS_C  = ROW_W'(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic             r_gmode_r, r_spv_r, r_ckv_r, r_cl_r, r_le_r, r_oe_r, r_sph_r;
    logic             r_ckv_q, r_cl_q, r_le_q, r_sph_q;
    logic [7:0]       r_data_r;
    logic             r_state;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_in_line;
    logic             r_err_overrun, r_err_short, r_err_order;

    logic             w_ckv_rise, w_cl_rise, w_le_rise, w_sph_fall, w_sph_rise;
    logic             w_active, w_fstart, w_in_line, w_row_vis;
    logic             w_cl_take, w_emit, w_ovr, w_order, w_le_evt, w_short;
    logic             w_row_adv, w_fdone;
    logic [COL_W-1:0] w_col, w_col_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gmode_r <= 1'b0;
            r_spv_r   <= 1'b1;
            r_ckv_r   <= 1'b0;
            r_cl_r    <= 1'b0;
            r_le_r    <= 1'b0;
            r_oe_r    <= 1'b0;
            r_sph_r   <= 1'b1;
            r_data_r  <= '0;
            r_ckv_q   <= 1'b0;
            r_cl_q    <= 1'b0;
            r_le_q    <= 1'b0;
            r_sph_q   <= 1'b1;
        end else begin
            r_gmode_r <= i_gmode;
            r_spv_r   <= i_spv;
            r_ckv_r   <= i_ckv;
            r_cl_r    <= i_cl;
            r_le_r    <= i_le;
            r_oe_r    <= i_oe;
            r_sph_r   <= i_sph;
            r_data_r  <= i_data;
            r_ckv_q   <= r_ckv_r;
            r_cl_q    <= r_cl_r;
            r_le_q    <= r_le_r;
            r_sph_q   <= r_sph_r;
        end
    end

    always_comb begin
        w_ckv_rise = r_ckv_r & ~r_ckv_q;
        w_cl_rise  = r_cl_r & ~r_cl_q;
        w_le_rise  = r_le_r & ~r_le_q;
        w_sph_fall = ~r_sph_r & r_sph_q;
        w_sph_rise = r_sph_r & ~r_sph_q;
        w_active   = (r_state == S_ACTIVE);
        w_fstart   = w_ckv_rise & ~r_spv_r & r_gmode_r;
        // A same-cycle sph fall must reset the column before the byte is placed.
        w_in_line  = w_sph_fall ? 1'b1 : (w_sph_rise ? 1'b0 : r_in_line);
        w_col      = w_sph_fall ? '0 : r_col;
        w_row_vis  = (r_row < ROWS_C);
        w_cl_take  = w_cl_rise & w_active & w_in_line & ~r_sph_r;
        w_emit     = w_cl_take & w_row_vis & (w_col < COLS_C);
        w_ovr      = w_cl_take & w_row_vis & (w_col >= COLS_C);
        w_col_next = w_emit ? w_col + 1'b1 : w_col;
        w_order    = w_cl_rise & ~r_sph_r & ~w_active;
        w_le_evt   = w_le_rise & w_active;
        w_short    = w_le_evt & w_row_vis & (w_col_next != COLS_C);
        w_row_adv  = w_active & r_gmode_r & w_ckv_rise & r_spv_r & w_row_vis;
        w_fdone    = w_row_adv & (r_row == LAST_ROW);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_in_line <= 1'b0;
        end else begin
            r_col     <= w_col_next;
            r_in_line <= w_in_line;
            if (w_fstart) begin
                r_state <= S_ACTIVE;
                r_row   <= '0;
            end else if (w_active && !r_gmode_r) begin
                r_state <= S_IDLE;
            end else if (w_row_adv) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pix_valid   <= 1'b0;
            o_pix_data    <= '0;
            o_pix_col     <= '0;
            o_pix_row     <= '0;
            o_line_done   <= 1'b0;
            o_line_bytes  <= '0;
            o_line_row    <= '0;
            o_line_oe     <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_order   <= 1'b0;
        end else begin
            o_pix_valid   <= w_emit;
            o_line_done   <= w_le_evt;
            o_frame_start <= w_fstart;
            o_frame_done  <= w_fdone;
            if (w_emit) begin
                o_pix_data <= r_data_r;
                o_pix_col  <= w_col;
                o_pix_row  <= r_row;
            end
            if (w_le_evt) begin
                o_line_bytes <= {1'b0, w_col_next};
                o_line_row   <= r_row;
                o_line_oe    <= r_oe_r;
            end
            // Set beats a coincident clear.
            r_err_overrun <= w_ovr     | (r_err_overrun & ~i_err_clr);
            r_err_short   <= w_short   | (r_err_short   & ~i_err_clr);
            r_err_order   <= w_order   | (r_err_order   & ~i_err_clr);
        end
    end

    assign o_busy        = r_state;
    assign o_err_overrun = r_err_overrun;
    assign o_err_short   = r_err_short;
    assign o_err_order   = r_err_order;

endmodule
